// File: rtl/dram_cache_if.sv
// rtl/dram_cache_if.sv - CPU-side and controller-side bundles for the DRAM read cache
// cpu_wait is the CPU stall strobe; master drives requests, slave answers them.
interface dram_cache_cpu_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] addr;
    logic                  read_enable;
    logic                  write_enable;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  cpu_wait;

    modport master (
        output addr, read_enable, write_enable, write_data,
        input  read_data, cpu_wait
    );
    modport slave (
        input  addr, read_enable, write_enable, write_data,
        output read_data, cpu_wait
    );
endinterface

interface dram_cache_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_ready;
    logic [DATA_WIDTH-1:0] mem_read_data;

    modport master (
        output mem_addr, mem_write_data, mem_read, mem_write,
        input  mem_ready, mem_read_data
    );
    modport slave (
        input  mem_addr, mem_write_data, mem_read, mem_write,
        output mem_ready, mem_read_data
    );
endinterface

// File: rtl/dram_cache.sv
// rtl/dram_cache.sv - direct-mapped write-through no-write-allocate DRAM read cache
// Read hits retire with no stall; misses and every write go to the controller.
module dram_cache #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int INDEX_BITS = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    dram_cache_cpu_if.slave cpu,
    dram_cache_mem_if.master mem
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_WDONE = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [LINES-1:0]      valid_q, valid_d;
    logic [TAG_W-1:0]      tag_mem [LINES];
    logic [DATA_WIDTH-1:0] data_mem [LINES];
    logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_W-1:0]      tag;
    logic                  hit;
    logic                  line_we;
    logic                  tag_we;
    logic [DATA_WIDTH-1:0] line_wdata;
    logic                  stall;
    logic                  unused_addr_bits;

    assign idx = cpu.addr[INDEX_BITS+1:2];
    assign tag = cpu.addr[ADDR_WIDTH-1:INDEX_BITS+2];
    assign hit = valid_q[idx] && (tag_mem[idx] == tag);
    assign unused_addr_bits = &{1'b0, cpu.addr[1:0]};

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        read_data_d = read_data_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        line_we     = 1'b0;
        tag_we      = 1'b0;
        line_wdata  = mem.mem_read_data;
        stall       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cpu.write_enable) begin
                    mem_addr_d  = {cpu.addr[ADDR_WIDTH-1:2], 2'b00};
                    mem_wdata_d = cpu.write_data;
                    state_d     = S_WRITE;
                    stall       = 1'b1;
                end else if (cpu.read_enable) begin
                    if (hit) begin
                        read_data_d = data_mem[idx];
                    end else begin
                        mem_addr_d = {cpu.addr[ADDR_WIDTH-1:2], 2'b00};
                        state_d    = S_FILL;
                        stall      = 1'b1;
                    end
                end
            end
            S_FILL: begin
                stall = 1'b1;
                if (mem.mem_ready) begin
                    line_we      = 1'b1;
                    tag_we       = 1'b1;
                    valid_d[idx] = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            S_WRITE: begin
                stall = 1'b1;
                if (mem.mem_ready) begin
                    // Update a resident line only; a write miss never allocates.
                    line_we    = hit;
                    line_wdata = mem_wdata_q;
                    state_d    = S_WDONE;
                end
            end
            S_WDONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            valid_q     <= '0;
            read_data_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            read_data_q <= read_data_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Arrays are not reset, but a completion that lands with reset must not write a line.
    always_ff @(posedge clk_i) begin
        if (!rst_i && line_we) begin
            data_mem[idx] <= line_wdata;
        end
        if (!rst_i && tag_we) begin
            tag_mem[idx] <= tag;
        end
    end

    assign cpu.read_data      = read_data_q;
    assign cpu.cpu_wait       = stall && !rst_i;
    assign mem.mem_addr       = mem_addr_q;
    assign mem.mem_write_data = mem_wdata_q;
    assign mem.mem_read       = (state_q == S_FILL);
    assign mem.mem_write      = (state_q == S_WRITE);
endmodule

// File: tb/tb_dram_cache.sv
// tb/tb_dram_cache.sv - scoreboard bench for dram_cache with a latency-programmable controller model
module tb_dram_cache;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IB = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dram_cache_cpu_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) cpu_if ();
    dram_cache_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

    dram_cache #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INDEX_BITS(IB)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .cpu   (cpu_if),
        .mem   (mem_if)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] sb_q [$];
    bit          mvalid [256];
    logic [21:0] mtag [256];

    int lat        = 1;
    int ctl_reads  = 0;
    int ctl_writes = 0;
    int overlap    = 0;
    bit busy       = 1'b0;
    int busy_cnt   = 0;

    function automatic logic [31:0] mem_get(input logic [31:0] a);
        logic [31:0] wa;
        wa = a & ~32'h3;
        if (mem_model.exists(wa)) return mem_model[wa];
        return wa ^ 32'h5A5A_0F0F;
    endfunction

    // Controller: counts lat cycles of a held request, then pulses mem_ready once.
    initial begin
        mem_if.mem_ready     = 1'b0;
        mem_if.mem_read_data = '0;
        forever begin
            @(posedge clk);
            #2;
            mem_if.mem_ready = 1'b0;
            if (mem_if.mem_read && mem_if.mem_write) overlap++;
            if (busy && !(mem_if.mem_read || mem_if.mem_write)) busy = 1'b0;
            if (!busy && (mem_if.mem_read || mem_if.mem_write)) begin
                busy = 1'b1;
                busy_cnt = 0;
            end
            if (busy) begin
                busy_cnt++;
                if (busy_cnt >= lat) begin
                    busy = 1'b0;
                    mem_if.mem_ready = 1'b1;
                    if (mem_if.mem_write) begin
                        mem_model[mem_if.mem_addr] = mem_if.mem_write_data;
                        ctl_writes++;
                    end else begin
                        mem_if.mem_read_data = mem_get(mem_if.mem_addr);
                        ctl_reads++;
                    end
                end
            end
        end
    end

    task automatic cpu_read(input logic [31:0] a, input int l);
        int cyc;
        int r0;
        bit miss;
        logic [31:0] wa;
        wa   = a & ~32'h3;
        miss = !(mvalid[a[9:2]] && mtag[a[9:2]] == a[31:10]);
        r0   = ctl_reads;
        lat  = l;
        cpu_if.addr = a;
        cpu_if.read_enable = 1'b1;
        cpu_if.write_enable = 1'b0;
        cyc = 0;
        #2;
        if (!miss) check("hit_no_mem_read", {31'b0, mem_if.mem_read}, 32'd0);
        while (cpu_if.cpu_wait && cyc < 50) begin
            @(posedge clk);
            #3;
            cyc++;
            if (cyc == 1) begin
                check("fill_mem_read", {31'b0, mem_if.mem_read}, 32'd1);
                check("fill_addr", mem_if.mem_addr, wa);
            end
        end
        check("read_stall_cycles", cyc, miss ? l + 1 : 0);
        sb_q.push_back(mem_get(wa));
        @(posedge clk);
        #1;
        cpu_if.read_enable = 1'b0;
        check("read_data", cpu_if.read_data, sb_q.pop_front());
        check("ctl_read_count", ctl_reads - r0, miss ? 1 : 0);
        mvalid[a[9:2]] = 1'b1;
        mtag[a[9:2]]   = a[31:10];
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, input bit both, input int l);
        int cyc;
        int r0;
        int w0;
        r0  = ctl_reads;
        w0  = ctl_writes;
        lat = l;
        cpu_if.addr = a;
        cpu_if.write_data = d;
        cpu_if.write_enable = 1'b1;
        cpu_if.read_enable = both;
        cyc = 0;
        #2;
        while (cpu_if.cpu_wait && cyc < 50) begin
            @(posedge clk);
            #3;
            cyc++;
            if (cyc == 1) begin
                check("wr_mem_write", {30'b0, mem_if.mem_read, mem_if.mem_write}, 32'd1);
                check("wr_addr", mem_if.mem_addr, a & ~32'h3);
                check("wr_data", mem_if.mem_write_data, d);
            end
        end
        check("write_stall_cycles", cyc, l + 1);
        @(posedge clk);
        #1;
        cpu_if.write_enable = 1'b0;
        cpu_if.read_enable = 1'b0;
        check("ctl_write_count", ctl_writes - w0, 1);
        check("wr_no_ctl_read", ctl_reads - r0, 0);
    endtask

    logic [31:0] addr_set [6];

    initial begin
        cpu_if.addr = '0;
        cpu_if.read_enable = 1'b0;
        cpu_if.write_enable = 1'b0;
        cpu_if.write_data = '0;
        mem_model[32'h0001_0000] = 32'hDEAD_BEEF;
        for (int i = 0; i < 256; i++) mvalid[i] = 1'b0;

        repeat (3) @(posedge clk);
        #3;
        check("rst_wait", {31'b0, cpu_if.cpu_wait}, 32'd0);
        check("rst_read_data", cpu_if.read_data, 32'd0);
        check("rst_mem_addr", mem_if.mem_addr, 32'd0);
        check("rst_mem_wdata", mem_if.mem_write_data, 32'd0);
        check("rst_mem_req", {30'b0, mem_if.mem_read, mem_if.mem_write}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        cpu_read(32'h0001_0000, 3);
        cpu_read(32'h0001_0000, 3);
        cpu_write(32'h0001_0000, 32'h1234_5678, 1'b0, 2);
        cpu_read(32'h0001_0000, 2);
        cpu_write(32'h0001_0400, 32'hCAFE_F00D, 1'b0, 1);
        cpu_read(32'h0001_0000, 1);
        cpu_read(32'h0001_0400, 1);
        cpu_read(32'h0001_0000, 2);
        cpu_read(32'h0002_0003, 2);
        cpu_write(32'h0003_0000, 32'h0BAD_F00D, 1'b1, 2);
        cpu_read(32'h0003_0000, 1);

        addr_set[0] = 32'h0001_0000;
        addr_set[1] = 32'h0001_0400;
        addr_set[2] = 32'h0001_0004;
        addr_set[3] = 32'h0002_0000;
        addr_set[4] = 32'h0002_0400;
        addr_set[5] = 32'h0001_0800;
        for (int i = 0; i < 30; i++) begin
            int sel;
            int l;
            sel = $urandom_range(0, 5);
            l   = $urandom_range(1, 4);
            if ($urandom_range(0, 9) < 6) cpu_read(addr_set[sel], l);
            else cpu_write(addr_set[sel], $urandom, bit'($urandom_range(0, 1)), l);
        end

        cpu_read(32'h0001_0000, 1);
        lat = 2;
        cpu_if.addr = 32'h0004_0000;
        cpu_if.read_enable = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        check("wait_during_rst", {31'b0, cpu_if.cpu_wait}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cpu_if.read_enable = 1'b0;
        #2;
        check("rst_drops_fill", {30'b0, mem_if.mem_read, mem_if.mem_write}, 32'd0);
        for (int i = 0; i < 256; i++) mvalid[i] = 1'b0;
        @(posedge clk);
        #1;
        cpu_read(32'h0001_0000, 1);
        cpu_read(32'h0004_0000, 1);

        check("req_overlap", overlap, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
